ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register for the 64-bit pipelined CPU; sits directly downstream of the ALU and captures its result and N/Z/V/C outputs.
- Holds the architectural NZCV flag register, which is written only by flag-setting ops (ADDS/SUBS).
- Resolves B.cond, CBZ and CBNZ in EX and registers the decision into MEM.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
WIDTH, 64, datapath width of result and store data
REGBITS, 5, register-specifier width

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-low
stall  in  1  hold all state this cycle
flush  in  1  replace incoming op with bubble
ex_valid  in  1  EX holds a real instruction
ex_result  in  WIDTH  ALU result
ex_negative, ex_zero, ex_overflow, ex_carry_out  in  1 each  ALU flags
ex_set_flags  in  1  op updates NZCV
ex_br_cond  in  1  op is B.cond
ex_cond  in  4  condition code
ex_cbz, ex_cbnz  in  1 each  op is CBZ/CBNZ; ALU passes Rt, so ex_zero is the test
ex_rd  in  REGBITS  destination register
ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control
ex_store_data  in  WIDTH  store operand
mem_valid  out  1  MEM op valid
mem_result, mem_store_data  out  WIDTH  registered data
mem_rd  out  REGBITS  registered destination
mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control
mem_branch_taken  out  1  registered branch decision
flag_n, flag_z, flag_v, flag_c  out  1 each  architectural flags

Behaviour:
- Latency: 1 cycle EX->MEM. All outputs are registered. No combinational input-to-output path.
- Priority per edge: reset > flush > stall > normal load.
- Reset (reset==0 at an edge): every output goes to 0, including flags and data. Reset asserted mid-operation discards the in-flight op.
- Flush:
  - mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken go to 0.
  - mem_result, mem_store_data and mem_rd go to 0.
  - Flags are NOT updated by the flushed op.
  - flush wins over a simultaneous stall.
- Stall (flush=0): every output, including flags, holds its value. The EX op is not consumed, so its flags are not written.
- Normal load:
  - mem_valid<=ex_valid.
  - Data and rd are copied from the inputs.
  - Control outputs and mem_branch_taken are ANDed with ex_valid, so a bubble carries no side effects.
- Flag register:
  - Condition: ex_valid & ex_set_flags & load.
  - Action: {N,Z,V,C}<={ex_negative,ex_zero,ex_overflow,ex_carry_out}.
  - Otherwise the flags hold.
- Branch decision:
  - taken = ex_valid & ((ex_br_cond & cond_true) | (ex_cbz & ex_zero) | (ex_cbnz & ~ex_zero)).
  - cond_true uses the current flag register, i.e. values before this edge. An immediately preceding SUBS has already written the flags one edge earlier, so no bypass is required.
- Condition codes (ex_cond):
  - 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C
  - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z
  - A GE N==V; B LT N!=V
  - C GT ~Z&(N==V); D LE Z|(N!=V)
  - E,F AL 1
- An op that is both flag-setting and a branch is illegal. There is no checking. The branch uses the old flags and the flags update.
- mem_result is a straight copy of ex_result, with no width changes.

Test Plan:
- Reset then load: reset=0 for 2 cycles -> all outputs 0. Release; drive ex_valid=1, result=64'h0123_4567_89AB_CDEF, rd=5, reg_write=1 -> next cycle mem_result matches, mem_rd=5, mem_reg_write=1, mem_valid=1.
- SUBS 3-5 then B.LT: cycle t ex_set_flags=1, N=1,Z=0,V=0,C=0; cycle t+1 ex_br_cond=1, cond=4'hB -> flag_n=1 after t; mem_branch_taken=1 after t+1. Repeat with cond=4'hA -> 0.
- Non-flag op preserves flags: after SUBS 5-5 (Z=1,C=1), an ADD with ex_zero=0, set_flags=0 -> flag_z stays 1; B.EQ (cond=0) taken.
- CBZ/CBNZ: ex_cbz=1, ex_zero=1 -> taken=1; ex_cbnz=1, ex_zero=1 -> taken=0; ex_valid=0 with ex_cbz=1, ex_zero=1 -> taken=0, mem_valid=0.
- Stall/flush:
  - Load A, then stall=1 for 3 cycles while the inputs change -> outputs hold A, and flags hold even with ex_set_flags=1.
  - Then stall=1, flush=1 -> mem_valid=0, controls 0, flags unchanged.
- Reset mid-stream: valid op with mem_mem_write=1 registered, then reset=0 in the same cycle as a flag-setting op -> all outputs 0 next edge, flags 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the ALU result and controls, owns the
// architectural NZCV flag register and resolves B.cond / CBZ / CBNZ so the
// branch decision arrives in MEM already registered.
module ex_mem_stage #(
    parameter int WIDTH   = 64,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [WIDTH-1:0]   ex_result,
    input  logic               ex_negative,
    input  logic               ex_zero,
    input  logic               ex_overflow,
    input  logic               ex_carry_out,
    input  logic               ex_set_flags,
    input  logic               ex_br_cond,
    input  logic [3:0]         ex_cond,
    input  logic               ex_cbz,
    input  logic               ex_cbnz,
    input  logic [REGBITS-1:0] ex_rd,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [WIDTH-1:0]   ex_store_data,
    output logic               mem_valid,
    output logic [WIDTH-1:0]   mem_result,
    output logic [WIDTH-1:0]   mem_store_data,
    output logic [REGBITS-1:0] mem_rd,
    output logic               mem_reg_write,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               mem_branch_taken,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_v,
    output logic               flag_c
);

    // Evaluate an ARM-style condition code against a set of NZCV flags.
    function automatic logic cond_holds(
        input logic [3:0] cond,
        input logic       n,
        input logic       z,
        input logic       v,
        input logic       c
    );
        logic res;
        case (cond)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = c;
            4'h3:    res = ~c;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = c & ~z;
            4'h9:    res = ~c | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            4'hE:    res = 1'b1;
            4'hF:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic               valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   store_data_r;
    logic [REGBITS-1:0] rd_r;
    logic               reg_write_r;
    logic               mem_read_r;
    logic               mem_write_r;
    logic               branch_taken_r;
    logic               flag_n_r;
    logic               flag_z_r;
    logic               flag_v_r;
    logic               flag_c_r;

    logic               load_s;
    logic               cond_true_s;
    logic               taken_s;
    logic               flag_we_s;

    // Branch decision and load/flag-write enables; the condition sees the
    // flags as they stand before this edge, so no bypass from a same-cycle op.
    always_comb begin
        load_s      = 1'b0;
        cond_true_s = 1'b0;
        taken_s     = 1'b0;
        flag_we_s   = 1'b0;
        if (reset && !flush && !stall) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        cond_true_s = cond_holds(ex_cond, flag_n_r, flag_z_r, flag_v_r, flag_c_r);
        taken_s     = ex_valid & ((ex_br_cond & cond_true_s)
                                | (ex_cbz  &  ex_zero)
                                | (ex_cbnz & ~ex_zero));
        flag_we_s   = ex_valid & ex_set_flags & load_s;
    end

    // Pipeline register: reset clears, flush inserts a zeroed bubble,
    // stall holds, otherwise capture EX with side effects gated by ex_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r        <= 1'b0;
            result_r       <= {WIDTH{1'b0}};
            store_data_r   <= {WIDTH{1'b0}};
            rd_r           <= {REGBITS{1'b0}};
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            branch_taken_r <= 1'b0;
        end else if (flush) begin
            valid_r        <= 1'b0;
            result_r       <= {WIDTH{1'b0}};
            store_data_r   <= {WIDTH{1'b0}};
            rd_r           <= {REGBITS{1'b0}};
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            branch_taken_r <= 1'b0;
        end else if (stall) begin
            valid_r        <= valid_r;
            result_r       <= result_r;
            store_data_r   <= store_data_r;
            rd_r           <= rd_r;
            reg_write_r    <= reg_write_r;
            mem_read_r     <= mem_read_r;
            mem_write_r    <= mem_write_r;
            branch_taken_r <= branch_taken_r;
        end else begin
            valid_r        <= ex_valid;
            result_r       <= ex_result;
            store_data_r   <= ex_store_data;
            rd_r           <= ex_rd;
            reg_write_r    <= ex_reg_write & ex_valid;
            mem_read_r     <= ex_mem_read  & ex_valid;
            mem_write_r    <= ex_mem_write & ex_valid;
            branch_taken_r <= taken_s;
        end
    end

    // Architectural NZCV: written only when a valid flag-setting op is consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
            flag_v_r <= 1'b0;
            flag_c_r <= 1'b0;
        end else if (flag_we_s) begin
            flag_n_r <= ex_negative;
            flag_z_r <= ex_zero;
            flag_v_r <= ex_overflow;
            flag_c_r <= ex_carry_out;
        end else begin
            flag_n_r <= flag_n_r;
            flag_z_r <= flag_z_r;
            flag_v_r <= flag_v_r;
            flag_c_r <= flag_c_r;
        end
    end

    assign mem_valid        = valid_r;
    assign mem_result       = result_r;
    assign mem_store_data   = store_data_r;
    assign mem_rd           = rd_r;
    assign mem_reg_write    = reg_write_r;
    assign mem_mem_read     = mem_read_r;
    assign mem_mem_write    = mem_write_r;
    assign mem_branch_taken = branch_taken_r;
    assign flag_n           = flag_n_r;
    assign flag_z           = flag_z_r;
    assign flag_v           = flag_v_r;
    assign flag_c           = flag_c_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stage.
module tb_ex_mem_stage;

    localparam int WIDTH   = 64;
    localparam int REGBITS = 5;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               flush;
    logic               ex_valid;
    logic [WIDTH-1:0]   ex_result;
    logic               ex_negative;
    logic               ex_zero;
    logic               ex_overflow;
    logic               ex_carry_out;
    logic               ex_set_flags;
    logic               ex_br_cond;
    logic [3:0]         ex_cond;
    logic               ex_cbz;
    logic               ex_cbnz;
    logic [REGBITS-1:0] ex_rd;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic [WIDTH-1:0]   ex_store_data;
    logic               mem_valid;
    logic [WIDTH-1:0]   mem_result;
    logic [WIDTH-1:0]   mem_store_data;
    logic [REGBITS-1:0] mem_rd;
    logic               mem_reg_write;
    logic               mem_mem_read;
    logic               mem_mem_write;
    logic               mem_branch_taken;
    logic               flag_n;
    logic               flag_z;
    logic               flag_v;
    logic               flag_c;

    int total_cnt;
    int bad_cnt;

    // Reference model state: expected outputs after the most recent edge.
    logic               m_valid;
    logic [WIDTH-1:0]   m_result;
    logic [WIDTH-1:0]   m_store;
    logic [REGBITS-1:0] m_rd;
    logic               m_rw;
    logic               m_mr;
    logic               m_mw;
    logic               m_bt;
    logic [3:0]         m_flags;   // {N,Z,V,C}

    logic [WIDTH-1:0]   saved_result;
    logic [3:0]         saved_flags;

    ex_mem_stage #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_negative(ex_negative), .ex_zero(ex_zero),
        .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
        .ex_set_flags(ex_set_flags), .ex_br_cond(ex_br_cond), .ex_cond(ex_cond),
        .ex_cbz(ex_cbz), .ex_cbnz(ex_cbnz), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
        .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_branch_taken(mem_branch_taken),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition codes come in complementary pairs: cond[3:1] picks a base
    // predicate and cond[0] inverts it, except the always pair.
    function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c, base;
        logic [2:0] sel;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        sel = cond[3:1];
        case (sel)
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (sel == 3'd7) return 1'b1;
        return base ^ cond[0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  64'(mem_valid),        64'(m_valid));
        chk({tag, ".result"}, mem_result,            m_result);
        chk({tag, ".store"},  mem_store_data,        m_store);
        chk({tag, ".rd"},     64'(mem_rd),           64'(m_rd));
        chk({tag, ".rw"},     64'(mem_reg_write),    64'(m_rw));
        chk({tag, ".mr"},     64'(mem_mem_read),     64'(m_mr));
        chk({tag, ".mw"},     64'(mem_mem_write),    64'(m_mw));
        chk({tag, ".taken"},  64'(mem_branch_taken), 64'(m_bt));
        chk({tag, ".flags"},  64'({flag_n, flag_z, flag_v, flag_c}), 64'(m_flags));
    endtask

    // Advance one edge: the model computes the next state from the inputs
    // currently driven, then all outputs are compared just after the edge.
    task automatic cycle(input string tag);
        logic               n_valid, n_rw, n_mr, n_mw, n_bt;
        logic [WIDTH-1:0]   n_result, n_store;
        logic [REGBITS-1:0] n_rd;
        logic [3:0]         n_flags;
        logic               op_taken;
        n_valid = m_valid; n_result = m_result; n_store = m_store; n_rd = m_rd;
        n_rw = m_rw; n_mr = m_mr; n_mw = m_mw; n_bt = m_bt; n_flags = m_flags;
        if (!reset) begin
            n_valid = 1'b0; n_result = '0; n_store = '0; n_rd = '0;
            n_rw = 1'b0; n_mr = 1'b0; n_mw = 1'b0; n_bt = 1'b0; n_flags = 4'h0;
        end else if (flush) begin
            n_valid = 1'b0; n_result = '0; n_store = '0; n_rd = '0;
            n_rw = 1'b0; n_mr = 1'b0; n_mw = 1'b0; n_bt = 1'b0;
        end else if (!stall) begin
            op_taken = 1'b0;
            if (ex_valid) begin
                if (ex_br_cond && model_cond(ex_cond, m_flags)) op_taken = 1'b1;
                if (ex_cbz && ex_zero)   op_taken = 1'b1;
                if (ex_cbnz && !ex_zero) op_taken = 1'b1;
            end
            n_valid  = ex_valid;
            n_result = ex_result;
            n_store  = ex_store_data;
            n_rd     = ex_rd;
            n_rw     = ex_valid ? ex_reg_write : 1'b0;
            n_mr     = ex_valid ? ex_mem_read  : 1'b0;
            n_mw     = ex_valid ? ex_mem_write : 1'b0;
            n_bt     = op_taken;
            if (ex_valid && ex_set_flags)
                n_flags = {ex_negative, ex_zero, ex_overflow, ex_carry_out};
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_result = n_result; m_store = n_store; m_rd = n_rd;
        m_rw = n_rw; m_mr = n_mr; m_mw = n_mw; m_bt = n_bt; m_flags = n_flags;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_result = '0;
        ex_negative = 1'b0; ex_zero = 1'b0; ex_overflow = 1'b0; ex_carry_out = 1'b0;
        ex_set_flags = 1'b0; ex_br_cond = 1'b0; ex_cond = 4'h0; ex_cbz = 1'b0;
        ex_cbnz = 1'b0; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_store_data = '0;
    endtask

    task automatic random_inputs();
        ex_valid      = ($urandom_range(0, 3) != 0);
        ex_result     = {$urandom(), $urandom()};
        ex_store_data = {$urandom(), $urandom()};
        ex_negative   = 1'($urandom_range(0, 1));
        ex_zero       = 1'($urandom_range(0, 1));
        ex_overflow   = 1'($urandom_range(0, 1));
        ex_carry_out  = 1'($urandom_range(0, 1));
        ex_set_flags  = 1'($urandom_range(0, 1));
        ex_br_cond    = 1'($urandom_range(0, 1));
        ex_cond       = 4'($urandom_range(0, 15));
        ex_cbz        = ($urandom_range(0, 3) == 0);
        ex_cbnz       = ($urandom_range(0, 3) == 0);
        ex_rd         = 5'($urandom_range(0, 31));
        ex_reg_write  = 1'($urandom_range(0, 1));
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_write  = 1'($urandom_range(0, 1));
    endtask

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        m_valid = 1'b0; m_result = '0; m_store = '0; m_rd = '0;
        m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_bt = 1'b0; m_flags = 4'h0;
        idle_inputs();
        ex_valid = 1'b1; ex_result = 64'hFFFF_FFFF_FFFF_FFFF; ex_mem_write = 1'b1;
        reset = 1'b0;
        cycle("rst0");
        cycle("rst1");
        chk("rst.valid", 64'(mem_valid), 64'd0);
        chk("rst.flags", 64'({flag_n, flag_z, flag_v, flag_c}), 64'd0);

        // Plain load.
        reset = 1'b1; idle_inputs();
        ex_valid = 1'b1; ex_result = 64'h0123_4567_89AB_CDEF; ex_rd = 5'd5; ex_reg_write = 1'b1;
        cycle("load");
        chk("load.result", mem_result, 64'h0123_4567_89AB_CDEF);
        chk("load.rd", 64'(mem_rd), 64'd5);

        // SUBS 3-5 then B.LT / B.GE.
        idle_inputs(); ex_valid = 1'b1; ex_set_flags = 1'b1; ex_negative = 1'b1;
        ex_result = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle("subs");
        chk("subs.n", 64'(flag_n), 64'd1);
        idle_inputs(); ex_valid = 1'b1; ex_br_cond = 1'b1; ex_cond = 4'hB;
        cycle("blt");
        chk("blt.taken", 64'(mem_branch_taken), 64'd1);
        ex_cond = 4'hA;
        cycle("bge");
        chk("bge.taken", 64'(mem_branch_taken), 64'd0);

        // SUBS 5-5, non-flag ADD, B.EQ.
        idle_inputs(); ex_valid = 1'b1; ex_set_flags = 1'b1; ex_zero = 1'b1; ex_carry_out = 1'b1;
        cycle("subs_eq");
        idle_inputs(); ex_valid = 1'b1; ex_result = 64'd9; ex_reg_write = 1'b1;
        cycle("add");
        chk("add.z", 64'(flag_z), 64'd1);
        idle_inputs(); ex_valid = 1'b1; ex_br_cond = 1'b1; ex_cond = 4'h0;
        cycle("beq");
        chk("beq.taken", 64'(mem_branch_taken), 64'd1);

        // CBZ / CBNZ / bubble CBZ.
        idle_inputs(); ex_valid = 1'b1; ex_cbz = 1'b1; ex_zero = 1'b1;
        cycle("cbz");
        chk("cbz.taken", 64'(mem_branch_taken), 64'd1);
        idle_inputs(); ex_valid = 1'b1; ex_cbnz = 1'b1; ex_zero = 1'b1;
        cycle("cbnz");
        chk("cbnz.taken", 64'(mem_branch_taken), 64'd0);
        idle_inputs(); ex_cbz = 1'b1; ex_zero = 1'b1;
        cycle("cbz_bub");
        chk("cbz_bub.taken", 64'(mem_branch_taken), 64'd0);

        // Load A, stall three cycles with changing inputs, then flush+stall.
        idle_inputs(); ex_valid = 1'b1; ex_result = 64'hA5A5_0000_1234_5678;
        ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_write = 1'b1; ex_store_data = 64'h55;
        cycle("loadA");
        saved_result = mem_result;
        saved_flags  = {flag_n, flag_z, flag_v, flag_c};
        for (int i = 0; i < 3; i++) begin
            random_inputs(); ex_valid = 1'b1; ex_set_flags = 1'b1;
            ex_negative = ~saved_flags[3]; stall = 1'b1;
            cycle("stall");
            chk("stall.result", mem_result, 64'hA5A5_0000_1234_5678);
            chk("stall.flags", 64'({flag_n, flag_z, flag_v, flag_c}), 64'(saved_flags));
        end
        stall = 1'b1; flush = 1'b1;
        cycle("flush");
        chk("flush.valid", 64'(mem_valid), 64'd0);
        chk("flush.mw", 64'(mem_mem_write), 64'd0);
        chk("flush.flags", 64'({flag_n, flag_z, flag_v, flag_c}), 64'(saved_flags));

        // Reset mid-stream while a flag-setting op is in EX.
        idle_inputs(); ex_valid = 1'b1; ex_mem_write = 1'b1; ex_result = 64'h77;
        cycle("store");
        chk("store.mw", 64'(mem_mem_write), 64'd1);
        idle_inputs(); ex_valid = 1'b1; ex_set_flags = 1'b1; ex_negative = 1'b1;
        ex_zero = 1'b1; ex_overflow = 1'b1; ex_carry_out = 1'b1; reset = 1'b0;
        cycle("midrst");
        chk("midrst.flags", 64'({flag_n, flag_z, flag_v, flag_c}), 64'd0);
        chk("midrst.mw", 64'(mem_mem_write), 64'd0);
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 31) != 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
